instr_fetch: RTL and testbench

- Sits between the program ROM (combinational, 10-bit word address, 16-bit data) and the F100-L execute core.
- Drives the ROM address every cycle and prefetches words into a 4-entry word FIFO.
- Assembles complete one- or two-word instructions and presents each one to the core over a valid/ready handshake.
- Accepts a redirect (jump, call or return target) from the core, which flushes all prefetched state.

---
 rtl/f100l_pkg.sv | 24 ++
 rtl/fetch_fifo.sv | 72 +++++++
 rtl/instr_fetch.sv | 128 ++++++++++++
 tb/tb_instr_fetch.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/f100l_pkg.sv
// Shared F100-L definitions: opcode field constants and instruction length decode.
package f100l_pkg;

  localparam logic [3:0] OP_NOP     = 4'hF;
  localparam logic [3:0] OP_JUMPGRP = 4'h0;

  // An instruction is two words when it is a conditional jump (jump group with
  // bits [7:6] = 2'b10) or a non-NOP operation whose low 11 bits are all zero,
  // meaning the operand/long address lives in the following word.
  function automatic logic is_two_word(input logic [15:0] word);
    logic [3:0] op;
    logic       result;
    op = word[15:12];
    if (op == OP_JUMPGRP) begin
      result = (word[7:6] == 2'b10);
    end else if (op == OP_NOP) begin
      result = 1'b0;
    end else begin
      result = (word[10:0] == 11'd0);
    end
    return result;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch word FIFO: stores {pc, word} pairs, exposes the two oldest entries
// so a two-word instruction can be assembled and popped in a single cycle.
module fetch_fifo #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_pc,
  input  logic [15:0]       push_word,
  input  logic [1:0]        pop,
  output logic [CNT_W-1:0]  count,
  output logic [ADDR_W-1:0] head0_pc,
  output logic [15:0]       head0_word,
  output logic [15:0]       head1_word
);

  localparam int ENTRY_W = ADDR_W + 16;

  logic [ENTRY_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [CNT_W-1:0]   count_r;
  logic [PTR_W-1:0]   rd_ptr_next_s;
  logic [ENTRY_W-1:0] head0_entry_s;
  logic [ENTRY_W-1:0] head1_entry_s;

  // Read ports for the oldest and second-oldest entries.
  always_comb begin
    rd_ptr_next_s = rd_ptr_r + PTR_W'(1'b1);
    head0_entry_s = mem_r[rd_ptr_r];
    head1_entry_s = mem_r[rd_ptr_next_s];
  end

  assign count      = count_r;
  assign head0_pc   = head0_entry_s[ENTRY_W-1:16];
  assign head0_word = head0_entry_s[15:0];
  assign head1_word = head1_entry_s[15:0];

  // Entry storage; a flush cycle never writes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (push && !flush) begin
      mem_r[wr_ptr_r] <= {push_pc, push_word};
    end
  end

  // Pointer and occupancy bookkeeping; flush empties the queue synchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else if (flush) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      rd_ptr_r <= rd_ptr_r + PTR_W'(pop);
      wr_ptr_r <= wr_ptr_r + PTR_W'(push);
      count_r  <= count_r + CNT_W'(push) - CNT_W'(pop);
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: drives the ROM address, prefetches into a small FIFO,
// assembles one- or two-word instructions into a registered output slot and
// hands them to the execute core over valid/ready. A redirect flushes everything.
module instr_fetch
  import f100l_pkg::*;
#(
  parameter int                ADDR_W   = 10,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [15:0]       rom_data,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [15:0]       instr_word0,
  output logic [15:0]       instr_word1,
  output logic              instr_two,
  output logic [ADDR_W-1:0] instr_pc
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] fetch_pc_r;
  logic              instr_valid_r;
  logic [15:0]       instr_word0_r;
  logic [15:0]       instr_word1_r;
  logic              instr_two_r;
  logic [ADDR_W-1:0] instr_pc_r;

  logic [CNT_W-1:0]  count_s;
  logic [ADDR_W-1:0] head0_pc_s;
  logic [15:0]       head0_word_s;
  logic [15:0]       head1_word_s;
  logic              two_s;
  logic [1:0]        need_s;
  logic              slot_free_s;
  logic              load_s;
  logic [1:0]        pop_s;
  logic              push_s;

  fetch_fifo #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush      (redirect),
    .push       (push_s),
    .push_pc    (fetch_pc_r),
    .push_word  (rom_data),
    .pop        (pop_s),
    .count      (count_s),
    .head0_pc   (head0_pc_s),
    .head0_word (head0_word_s),
    .head1_word (head1_word_s)
  );

  // Decide slot load, FIFO pop and ROM fetch; a redirect suppresses all of them.
  always_comb begin
    two_s       = is_two_word(head0_word_s);
    need_s      = two_s ? 2'd2 : 2'd1;
    slot_free_s = !instr_valid_r || instr_ready;
    if (redirect) begin
      load_s = 1'b0;
    end else begin
      load_s = slot_free_s && (count_s >= CNT_W'(need_s));
    end
    if (load_s) begin
      pop_s = need_s;
    end else begin
      pop_s = 2'd0;
    end
    // Room is judged after this cycle's pop so a full FIFO can still stream.
    if (redirect) begin
      push_s = 1'b0;
    end else begin
      push_s = (count_s - CNT_W'(pop_s)) < CNT_W'(DEPTH);
    end
  end

  // Fetch address: jumps on redirect, advances (wrapping) on each push.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc_r <= RESET_PC;
    end else if (redirect) begin
      fetch_pc_r <= redirect_pc;
    end else if (push_s) begin
      fetch_pc_r <= fetch_pc_r + ADDR_W'(1'b1);
    end
  end

  // Registered instruction slot; holds while stalled, empties after a fire with no refill.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      instr_valid_r <= 1'b0;
      instr_word0_r <= 16'h0000;
      instr_word1_r <= 16'h0000;
      instr_two_r   <= 1'b0;
      instr_pc_r    <= '0;
    end else if (redirect) begin
      instr_valid_r <= 1'b0;
      instr_word0_r <= 16'h0000;
      instr_word1_r <= 16'h0000;
      instr_two_r   <= 1'b0;
      instr_pc_r    <= '0;
    end else if (load_s) begin
      instr_valid_r <= 1'b1;
      instr_word0_r <= head0_word_s;
      instr_word1_r <= two_s ? head1_word_s : 16'h0000;
      instr_two_r   <= two_s;
      instr_pc_r    <= head0_pc_s;
    end else if (instr_valid_r && instr_ready) begin
      instr_valid_r <= 1'b0;
    end
  end

  assign rom_address = fetch_pc_r;
  assign instr_valid = instr_valid_r;
  assign instr_word0 = instr_word0_r;
  assign instr_word1 = instr_word1_r;
  assign instr_two   = instr_two_r;
  assign instr_pc    = instr_pc_r;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch with a combinational ROM model.
module tb_instr_fetch;

  logic        clk;
  logic        reset_n;
  logic [9:0]  rom_address;
  logic [15:0] rom_data;
  logic        redirect;
  logic [9:0]  redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr_word0;
  logic [15:0] instr_word1;
  logic        instr_two;
  logic [9:0]  instr_pc;

  logic [15:0] rom_mem [1024];
  int          n_checks;
  int          n_fails;

  assign rom_data = rom_mem[rom_address];

  instr_fetch dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .rom_address (rom_address),
    .rom_data    (rom_data),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_word0 (instr_word0),
    .instr_word1 (instr_word1),
    .instr_two   (instr_two),
    .instr_pc    (instr_pc)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string tag, input int max_cycles);
    int n;
    n = 0;
    while (!instr_valid && n < max_cycles) begin
      step();
      n++;
    end
    check_eq({tag, "_valid"}, 32'(instr_valid), 32'd1);
  endtask

  // Every word defaults to a single-word NOP tagged with its own address.
  task automatic rom_default();
    for (int i = 0; i < 1024; i++) begin
      rom_mem[i] = 16'hF000 | 16'(i);
    end
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  initial begin
    n_checks    = 0;
    n_fails     = 0;
    reset_n     = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 10'd0;
    instr_ready = 1'b0;
    rom_default();

    // Reset state.
    #2;
    check_eq("rst_valid", 32'(instr_valid), 32'd0);
    check_eq("rst_word0", 32'(instr_word0), 32'h0);
    check_eq("rst_word1", 32'(instr_word1), 32'h0);
    check_eq("rst_two", 32'(instr_two), 32'd0);
    check_eq("rst_pc", 32'(instr_pc), 32'd0);
    check_eq("rst_addr", 32'(rom_address), 32'd0);

    // Two-word immediate then a single-word NOP.
    rom_mem[0] = 16'h8000;
    rom_mem[1] = 16'h0015;
    rom_mem[2] = 16'hF000;
    instr_ready = 1'b1;
    apply_reset();
    wait_valid("t1_first", 6);
    check_eq("t1_word0", 32'(instr_word0), 32'h8000);
    check_eq("t1_word1", 32'(instr_word1), 32'h0015);
    check_eq("t1_two", 32'(instr_two), 32'd1);
    check_eq("t1_pc", 32'(instr_pc), 32'd0);
    step();
    wait_valid("t1_second", 3);
    check_eq("t1_n_word0", 32'(instr_word0), 32'hF000);
    check_eq("t1_n_two", 32'(instr_two), 32'd0);
    check_eq("t1_n_word1", 32'(instr_word1), 32'h0);
    check_eq("t1_n_pc", 32'(instr_pc), 32'd2);

    // Stall with a conditional jump held in the slot, then stream.
    rom_default();
    rom_mem[0] = 16'h00B0;
    rom_mem[1] = 16'h2007;
    rom_mem[2] = 16'h00EF;
    rom_mem[3] = 16'h0400;
    instr_ready = 1'b0;
    apply_reset();
    wait_valid("t2_first", 6);
    for (int k = 0; k < 5; k++) begin
      check_eq("t2_hold_word0", 32'(instr_word0), 32'h00B0);
      check_eq("t2_hold_word1", 32'(instr_word1), 32'h2007);
      check_eq("t2_hold_pc", 32'(instr_pc), 32'd0);
      check_eq("t2_hold_valid", 32'(instr_valid), 32'd1);
      step();
    end
    check_eq("t2_full_addr", 32'(rom_address), 32'd6);
    step();
    check_eq("t2_full_addr2", 32'(rom_address), 32'd6);
    instr_ready = 1'b1;
    step();
    check_eq("t2_a_valid", 32'(instr_valid), 32'd1);
    check_eq("t2_a_pc", 32'(instr_pc), 32'd2);
    check_eq("t2_a_word0", 32'(instr_word0), 32'h00EF);
    step();
    check_eq("t2_b_valid", 32'(instr_valid), 32'd1);
    check_eq("t2_b_pc", 32'(instr_pc), 32'd3);
    check_eq("t2_b_word0", 32'(instr_word0), 32'h0400);

    // Redirect while valid and stalled.
    instr_ready = 1'b0;
    step();
    step();
    redirect    = 1'b1;
    redirect_pc = 10'd7;
    step();
    redirect = 1'b0;
    check_eq("t3_flush_valid", 32'(instr_valid), 32'd0);
    check_eq("t3_addr", 32'(rom_address), 32'd7);
    step();
    check_eq("t3_lat1_valid", 32'(instr_valid), 32'd0);
    step();
    check_eq("t3_lat2_valid", 32'(instr_valid), 32'd1);
    check_eq("t3_pc", 32'(instr_pc), 32'd7);
    check_eq("t3_word0", 32'(instr_word0), 32'hF007);

    // Redirect in the same cycle as a firing handshake at pc 5.
    instr_ready = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 10'd3;
    step();
    redirect = 1'b0;
    begin
      int n;
      n = 0;
      while (!(instr_valid && instr_pc == 10'd5) && n < 8) begin
        step();
        n++;
      end
    end
    check_eq("t4_at5", 32'(instr_pc), 32'd5);
    redirect    = 1'b1;
    redirect_pc = 10'd20;
    step();
    redirect = 1'b0;
    check_eq("t4_flush_valid", 32'(instr_valid), 32'd0);
    wait_valid("t4_next", 4);
    check_eq("t4_pc", 32'(instr_pc), 32'd20);
    check_eq("t4_word0", 32'(instr_word0), 32'hF014);

    // Two-word instruction straddling the address wrap.
    rom_mem[1023] = 16'h8000;
    rom_mem[0]    = 16'h1234;
    rom_mem[1]    = 16'hF001;
    redirect      = 1'b1;
    redirect_pc   = 10'd1023;
    step();
    redirect = 1'b0;
    wait_valid("t5_first", 5);
    check_eq("t5_word0", 32'(instr_word0), 32'h8000);
    check_eq("t5_word1", 32'(instr_word1), 32'h1234);
    check_eq("t5_two", 32'(instr_two), 32'd1);
    check_eq("t5_pc", 32'(instr_pc), 32'd1023);
    step();
    wait_valid("t5_second", 3);
    check_eq("t5_n_pc", 32'(instr_pc), 32'd1);
    check_eq("t5_n_word0", 32'(instr_word0), 32'hF001);

    // Asynchronous reset mid-stream with the FIFO three-quarters full.
    rom_default();
    instr_ready = 1'b0;
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      step();
    end
    check_eq("t6_pre_valid", 32'(instr_valid), 32'd1);
    check_eq("t6_pre_addr", 32'(rom_address), 32'd4);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("t6_async_valid", 32'(instr_valid), 32'd0);
    check_eq("t6_async_word0", 32'(instr_word0), 32'h0);
    check_eq("t6_async_addr", 32'(rom_address), 32'd0);
    step();
    reset_n     = 1'b1;
    instr_ready = 1'b1;
    step();
    check_eq("t6_lat1_valid", 32'(instr_valid), 32'd0);
    step();
    check_eq("t6_lat2_valid", 32'(instr_valid), 32'd1);
    check_eq("t6_pc", 32'(instr_pc), 32'd0);
    check_eq("t6_word0", 32'(instr_word0), 32'hF000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
